// File: rtl/pipe_wb_stage.sv
// MEM->WB write-back register with valid/ready handshake and a two-entry skid buffer.
// Carries NCH independent write-back channels; counts stalled cycles.

module pipe_wb_lane #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic              vld,
    input  logic              we,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] wr,
    output logic              out_we,
    output logic [DATA_W-1:0] out_wd,
    output logic [ADDR_W-1:0] out_wr
);
    logic x0_hit;

    assign x0_hit = (ZERO_SUPPRESS != 0) && (wr == '0);
    assign out_we = vld & we & ~x0_hit;
    assign out_wd = vld ? wd : '0;
    assign out_wr = vld ? wr : '0;
endmodule

module pipe_wb_stage #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int NCH           = 1,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH-1:0]        in_we,
    input  logic [NCH*DATA_W-1:0] in_wd,
    input  logic [NCH*ADDR_W-1:0] in_wr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH-1:0]        out_we,
    output logic [NCH*DATA_W-1:0] out_wd,
    output logic [NCH*ADDR_W-1:0] out_wr,
    output logic [CNT_W-1:0]      stall_cnt
);
    typedef struct packed {
        logic [NCH-1:0]             we;
        logic [NCH-1:0][DATA_W-1:0] wd;
        logic [NCH-1:0][ADDR_W-1:0] wr;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state, state_nxt;
    bundle_t          m_q, s_q, m_nxt, s_nxt, in_b;
    logic             in_ready_q;
    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] cnt_q;

    assign in_b      = {in_we, in_wd, in_wr};
    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_nxt = state;
        m_nxt     = m_q;
        s_nxt     = s_q;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    state_nxt = ONE;
                    m_nxt     = in_b;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_nxt = in_b;
                    end else if (in_xfer) begin
                        state_nxt = TWO;
                        s_nxt     = in_b;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (out_xfer) begin
                    state_nxt = ONE;
                    m_nxt     = s_q;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so WB back-pressure never
    // reaches MEM through a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            m_q        <= '0;
            s_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
            m_q        <= m_nxt;
            s_q        <= s_nxt;
            if (out_valid && !out_ready && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        pipe_wb_lane #(
            .DATA_W       (DATA_W),
            .ADDR_W       (ADDR_W),
            .ZERO_SUPPRESS(ZERO_SUPPRESS)
        ) u_lane (
            .vld   (out_valid),
            .we    (m_q.we[k]),
            .wd    (m_q.wd[k]),
            .wr    (m_q.wr[k]),
            .out_we(out_we[k]),
            .out_wd(out_wd[k*DATA_W +: DATA_W]),
            .out_wr(out_wr[k*ADDR_W +: ADDR_W])
        );
    end
endmodule

// File: tb/tb_pipe_wb_stage.sv
// Bench for pipe_wb_stage: queue model checked every cycle on a 2-channel instance,
// plus literal checks on it and on a 1-channel, no-suppress, 4-bit-counter instance.

module tb_pipe_wb_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready, in_ready, out_valid;
    logic [1:0]  in_we, out_we;
    logic [63:0] in_wd, out_wd;
    logic [9:0]  in_wr, out_wr;
    logic [15:0] stall_cnt;

    logic        b_valid, b_ready_in, b_flush, b_ordy, b_ovld, b_owe;
    logic        b_we;
    logic [31:0] b_wd, b_owd;
    logic [4:0]  b_wr, b_owr;
    logic [3:0]  b_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_wb_stage #(.DATA_W(32), .ADDR_W(5), .NCH(2), .ZERO_SUPPRESS(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_wd(in_wd), .in_wr(in_wr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_we(out_we), .out_wd(out_wd), .out_wr(out_wr),
        .stall_cnt(stall_cnt)
    );

    pipe_wb_stage #(.DATA_W(32), .ADDR_W(5), .NCH(1), .ZERO_SUPPRESS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready_in), .in_we(b_we),
        .in_wd(b_wd), .in_wr(b_wr), .flush(b_flush), .out_valid(b_ovld),
        .out_ready(b_ordy), .out_we(b_owe), .out_wd(b_owd), .out_wr(b_owr),
        .stall_cnt(b_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: a FIFO of at most two accepted bundles.
    typedef struct {
        logic [1:0]  we;
        logic [63:0] wd;
        logic [9:0]  wr;
    } bund_t;

    bund_t q[$];
    int    mcnt = 0;
    bit    init = 0;

    always @(posedge clk) begin
        bit ov, ir;
        bund_t b;
        if (rst) begin
            q.delete();
            mcnt = 0;
            init = 1;
        end else if (init) begin
            ov = (q.size() > 0);
            ir = (q.size() < 2);
            if (ov && !out_ready && mcnt < 65535) mcnt++;
            if (flush) q.delete();
            else begin
                if (ov && out_ready) void'(q.pop_front());
                if (in_valid && ir) begin
                    b.we = in_we; b.wd = in_wd; b.wr = in_wr;
                    q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] ewe;
        if (init) begin
            ewe = '0;
            if (q.size() > 0)
                for (int k = 0; k < 2; k++)
                    ewe[k] = q[0].we[k] && (q[0].wr[k*5 +: 5] != 5'd0);
            chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("m_in_ready",  64'(in_ready),  64'(q.size() < 2));
            chk("m_out_we",    64'(out_we),    64'(ewe));
            chk("m_out_wd",    out_wd, (q.size() > 0) ? q[0].wd : 64'd0);
            chk("m_out_wr",    64'(out_wr), (q.size() > 0) ? 64'(q[0].wr) : 64'd0);
            chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seta(input logic v, input logic [1:0] we, input logic [31:0] wd1,
                        input logic [31:0] wd0, input logic [4:0] wr1, input logic [4:0] wr0);
        in_valid = v; in_we = we; in_wd = {wd1, wd0}; in_wr = {wr1, wr0};
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 0;
        seta(0, 2'b00, 0, 0, 0, 0);
        b_valid = 0; b_flush = 0; b_ordy = 0; b_we = 0; b_wd = 0; b_wr = 0;
        step(); step();
        rst = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_stall",     64'(stall_cnt), 64'd0);

        // pass-through with back-to-back bundles
        out_ready = 1;
        seta(1, 2'b01, 0, 32'h12345678, 0, 5'd5);
        step();
        chk("pt_valid", 64'(out_valid), 64'd1);
        chk("pt_we",    64'(out_we), 64'd1);
        chk("pt_wd",    out_wd, 64'h12345678);
        chk("pt_wr",    64'(out_wr), 64'd5);
        for (int i = 0; i < 3; i++) begin
            seta(1, 2'b11, 32'h100 + i, 32'h200 + i, 5'(i + 10), 5'(i + 20));
            step();
        end
        chk("pt_b2b_wr", 64'(out_wr), {54'd0, 5'd12, 5'd22});
        seta(0, 2'b00, 0, 0, 0, 0);
        step();

        // back-pressure skid: A, B accepted, C held off
        out_ready = 0;
        seta(1, 2'b01, 0, 32'hA, 0, 5'd1); step();
        seta(1, 2'b01, 0, 32'hB, 0, 5'd2); step();
        chk("skid_in_ready_low", 64'(in_ready), 64'd0);
        seta(1, 2'b01, 0, 32'hC, 0, 5'd3); step(); step();
        chk("skid_stall3", 64'(stall_cnt), 64'd3);
        chk("skid_first_A", 64'(out_wr), 64'd1);
        out_ready = 1; step();
        chk("skid_then_B", 64'(out_wr), 64'd2);
        step();
        chk("skid_then_C", 64'(out_wr), 64'd3);
        seta(0, 2'b00, 0, 0, 0, 0); step();
        chk("skid_drained", 64'(out_valid), 64'd0);
        chk("skid_stall_hold", 64'(stall_cnt), 64'd3);

        // x0 suppression on both instances
        seta(1, 2'b11, 32'h1, 32'hDEADBEEF, 5'd9, 5'd0);
        b_valid = 1; b_we = 1; b_wd = 32'hDEADBEEF; b_wr = 5'd0; b_ordy = 1;
        step();
        chk("x0_suppressed", 64'(out_we), 64'b10);
        chk("x0_wd_kept", out_wd, {32'h1, 32'hDEADBEEF});
        chk("x0_b_we", 64'(b_owe), 64'd1);
        chk("x0_b_wd", 64'(b_owd), 64'hDEADBEEF);
        b_valid = 0;
        seta(0, 2'b00, 0, 0, 0, 0); step();

        // flush in TWO with an input offered
        out_ready = 0;
        seta(1, 2'b01, 0, 32'hD, 0, 5'd4); step();
        seta(1, 2'b01, 0, 32'hE, 0, 5'd6); step();
        flush = 1;
        seta(1, 2'b01, 0, 32'hF, 0, 5'd7); step();
        flush = 0;
        seta(0, 2'b00, 0, 0, 0, 0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_stall_kept", 64'(stall_cnt), 64'd5);
        step();
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // multi-channel bundle, then flush while WB is consuming
        out_ready = 1;
        seta(1, 2'b10, 32'hAAAA0000, 32'h5555, 5'd7, 5'd3); step();
        chk("mc_we", 64'(out_we), 64'b10);
        chk("mc_wr", 64'(out_wr), {54'd0, 5'd7, 5'd3});
        chk("mc_wd", out_wd, {32'hAAAA0000, 32'h00005555});
        flush = 1;
        seta(1, 2'b11, 32'h77, 32'h66, 5'd8, 5'd9); step();
        flush = 0;
        chk("mc_flush_empty", 64'(out_valid), 64'd0);

        // directed mix of valid/ready/flush patterns
        for (int i = 0; i < 40; i++) begin
            seta(i % 3 != 0, 2'(i), ~32'(i), 32'h10000000 + i, 5'(i + 3), 5'(i));
            out_ready = (i % 4) < 2;
            flush = (i == 17);
            step();
        end
        flush = 0;
        seta(0, 2'b00, 0, 0, 0, 0); out_ready = 1;
        step(); step();

        // reset (together with flush) while in TWO
        out_ready = 0;
        seta(1, 2'b01, 0, 32'h11, 0, 5'd1); step();
        seta(1, 2'b01, 0, 32'h22, 0, 5'd2); step();
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        seta(0, 2'b00, 0, 0, 0, 0);
        rst = 1; flush = 1; step();
        rst = 0; flush = 0;
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_we",    64'(out_we), 64'd0);
        chk("rst2_wd",    out_wd, 64'd0);
        chk("rst2_wr",    64'(out_wr), 64'd0);
        chk("rst2_stall", 64'(stall_cnt), 64'd0);
        chk("rst2_ready", 64'(in_ready), 64'd1);

        // 4-bit stall counter saturation on the second instance
        b_valid = 1; b_we = 1; b_wd = 32'h5; b_wr = 5'd5; b_ordy = 0;
        step();
        b_valid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) chk("sat_b_14", 64'(b_cnt), 64'd14);
            if (i == 14) chk("sat_b_15", 64'(b_cnt), 64'd15);
        end
        chk("sat_b_hold", 64'(b_cnt), 64'd15);
        chk("sat_b_in_ready", 64'(b_ready_in), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
